// File: rtl/ghash_sequencer.sv
// ghash_sequencer: feeds AAD, ciphertext and length blocks through one
// shared serial GF(2^128) multiplier to accumulate the GCM GHASH.
module ghash_sequencer #(
   parameter int BLK_W       = 128,
   parameter int MUL_TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:BLK_W-1] h_key,
   input  logic             msg_start,
   input  logic [63:0]      aad_bits,
   input  logic [63:0]      ct_bits,
   input  logic [0:BLK_W-1] blk_data,
   input  logic             blk_valid,
   input  logic             blk_last,
   output logic             blk_ready,
   output logic             mul_start,
   output logic [0:BLK_W-1] mul_x,
   output logic [0:BLK_W-1] mul_h,
   input  logic [0:BLK_W-1] mul_product,
   input  logic             mul_done,
   output logic [0:BLK_W-1] ghash_out,
   output logic             ghash_valid,
   output logic             busy,
   output logic             err_timeout
);

   localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BLK,
      MUL,
      GAP,
      LEN_LOAD,
      DONE
   } state_t;

   state_t           state;
   logic [0:BLK_W-1] y;
   logic [63:0]      aad_r;
   logic [63:0]      ct_r;
   logic             last_flag;
   logic             len_phase;
   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         y           <= '0;
         aad_r       <= '0;
         ct_r        <= '0;
         last_flag   <= 1'b0;
         len_phase   <= 1'b0;
         tmo_cnt     <= '0;
         blk_ready   <= 1'b0;
         mul_start   <= 1'b0;
         mul_x       <= '0;
         mul_h       <= '0;
         ghash_out   <= '0;
         ghash_valid <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         ghash_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (msg_start) begin
                  mul_h       <= h_key;
                  aad_r       <= aad_bits;
                  ct_r        <= ct_bits;
                  y           <= '0;
                  len_phase   <= 1'b0;
                  err_timeout <= 1'b0;
                  busy        <= 1'b1;
                  // nothing to hash but the all-zero length block
                  if (aad_bits == '0 && ct_bits == '0) begin
                     state <= LEN_LOAD;
                  end else begin
                     blk_ready <= 1'b1;
                     state     <= WAIT_BLK;
                  end
               end
            end
            WAIT_BLK: begin
               if (blk_valid) begin
                  mul_x     <= y ^ blk_data;
                  last_flag <= blk_last;
                  blk_ready <= 1'b0;
                  mul_start <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= MUL;
               end
            end
            MUL: begin
               if (mul_done) begin
                  y         <= mul_product;
                  mul_start <= 1'b0;
                  state     <= GAP;
               end else if (tmo_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  mul_start   <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               // one idle cycle lets the multiplier drop done and reload
               if (len_phase) begin
                  ghash_out   <= y;
                  ghash_valid <= 1'b1;
                  state       <= DONE;
               end else if (last_flag) begin
                  state <= LEN_LOAD;
               end else begin
                  blk_ready <= 1'b1;
                  state     <= WAIT_BLK;
               end
            end
            LEN_LOAD: begin
               mul_x     <= y ^ {aad_r, ct_r};
               len_phase <= 1'b1;
               mul_start <= 1'b1;
               tmo_cnt   <= '0;
               state     <= MUL;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
